change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4: eject pulse width in clk cycles (1..15).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: max cycles spent waiting for eject_ack (1..255).
REQ-003 SHALL have parameter TUBE_INIT, default 10: coins per tube after reset/refill (0..15).
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to pay out amount.
REQ-007 amount  in  8  change due in dollars; sampled on accepted start.
REQ-008 eject_ack  in  1  coin mechanism confirms one coin dropped.
REQ-009 refill  in  1  reload all tubes to TUBE_INIT.
REQ-010 eject5 / eject2 / eject1  out  1 each  coin-release strobes for $5/$2/$1.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse: full amount paid.
REQ-013 fault  out  1  sticky: shortfall or ack timeout; cleared by next accepted start or rst.
REQ-014 remaining  out  8  unpaid balance.
REQ-015 tube5 / tube2 / tube1  out  4 each  coins left per denomination.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
REQ-017 IDLE: start accepted -> remaining<=amount, fault<=0, next SELECT; start while busy SHALL be ignored.
REQ-018 SELECT (one cycle): remaining==0 -> DONE; else pick largest d in {5,2,1} with d<=remaining and tube_d>0 -> EJECT; none eligible -> FAULT.
REQ-019 EJECT: exactly one matching eject strobe high for exactly PULSE_CYCLES consecutive cycles, then WAIT_ACK; strobes never overlap.
REQ-020 WAIT_ACK: on eject_ack -> remaining -= d, tube_d -= 1 (same edge), next SELECT.
REQ-021 WAIT_ACK: counter reaches ACK_TIMEOUT without ack -> FAULT; remaining and tubes unchanged.
REQ-022 eject_ack outside WAIT_ACK SHALL be ignored.
REQ-023 DONE: done=1 one cycle, next IDLE; FAULT: fault<=1, next IDLE, remaining holds unpaid balance.
REQ-024 Latency: start accepted at edge N -> SELECT at N+1 -> first strobe high at N+2.
REQ-025 start with amount==0 -> done pulse at N+2, no strobes.
REQ-026 refill honoured only in IDLE; ignored while busy; refill and start same cycle -> refill applied, start accepted, selection uses refilled counts.
REQ-027 Tube counters SHALL never underflow (d eligible only if tube_d>0).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst at any time, including mid-ejection, SHALL force IDLE within one edge: strobes, busy, done, fault = 0; remaining = 0; tubes = TUBE_INIT; counters = 0.

Structure
REQ-030 State encoding, denomination values (5/2/1) and default parameter values SHALL live in the shared vending package.
REQ-031 Strobe-width/timeout counting SHALL be one sub-module, pulse_timer (load, count, expire), reused for EJECT and WAIT_ACK.
REQ-032 Controller's change_due feeds amount; controller's change-issue pulse feeds start.

Verification
REQ-033 amount=8, TUBE_INIT=10, ack 2 cycles after each strobe -> strobes 5,2,1 in order, each 4 cycles; done; remaining=0; tubes 9/9/9.
REQ-034 amount=2 -> single eject2, done; tube2=9, tube5=tube1=10.
REQ-035 TUBE_INIT=1, amount=11 -> eject 5,2,1 then fault=1, remaining=3, tubes 0/0/0, no done; refill -> tubes 1/1/1.
REQ-036 amount=5, eject_ack held low -> fault after 4+255 cycles of strobe+wait, remaining=5, tube5=10.
REQ-037 start pulsed during EJECT -> ignored, payout unaffected; rst asserted during WAIT_ACK -> next cycle busy=0, remaining=0, tubes=TUBE_INIT, strobes low.
REQ-038 amount=0 -> done at N+2, busy high two cycles, no strobes.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: FSM states, coin denominations, defaults.
// Also hosts the greedy coin-selection helper used by the dispenser.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        DEN_NONE,
        DEN_5,
        DEN_2,
        DEN_1
    } denom_t;

    localparam logic [7:0] VAL_5 = 8'd5;
    localparam logic [7:0] VAL_2 = 8'd2;
    localparam logic [7:0] VAL_1 = 8'd1;

    localparam int PULSE_CYCLES_DEF = 4;
    localparam int ACK_TIMEOUT_DEF  = 255;
    localparam int TUBE_INIT_DEF    = 10;

    // Largest coin not exceeding the balance whose tube is not empty.
    function automatic denom_t pick_denom(
        input logic [7:0] rem,
        input logic [3:0] t5,
        input logic [3:0] t2,
        input logic [3:0] t1
    );
        if (rem >= VAL_5 && t5 != 4'd0)
            return DEN_5;
        else if (rem >= VAL_2 && t2 != 4'd0)
            return DEN_2;
        else if (rem >= VAL_1 && t1 != 4'd0)
            return DEN_1;
        else
            return DEN_NONE;
    endfunction

    function automatic logic [7:0] denom_value(input denom_t d);
        case (d)
            DEN_5:   return VAL_5;
            DEN_2:   return VAL_2;
            DEN_1:   return VAL_1;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter shared by strobe width and ack timeout.
// expire flags the last counting cycle of a loaded interval.
module pulse_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       count,
    output logic       expire
);

    logic [7:0] cnt;

    assign expire = count && (cnt == 8'd1);

    // Load takes priority so a new interval can start on an expiring cycle.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else if (load)
            cnt <= load_val;
        else if (count && cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy $5/$2/$1 payout with strobe and ack
// handshake, per-tube stock tracking, shortfall and timeout faults.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int TUBE_INIT    = TUBE_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       eject_ack,
    input  logic       refill,
    output logic       eject5,
    output logic       eject2,
    output logic       eject1,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remaining,
    output logic [3:0] tube5,
    output logic [3:0] tube2,
    output logic [3:0] tube1
);

    state_t     state;
    state_t     state_nx;
    denom_t     sel;
    denom_t     cand;
    denom_t     den_nx;
    logic       tmr_load;
    logic       tmr_count;
    logic       tmr_expire;
    logic [7:0] tmr_val;
    logic       busy_nx;
    logic       done_nx;
    logic       e5_nx;
    logic       e2_nx;
    logic       e1_nx;

    assign cand      = pick_denom(remaining, tube5, tube2, tube1);
    assign den_nx    = (state == ST_SELECT) ? cand : sel;
    assign tmr_count = (state == ST_EJECT) || (state == ST_WAIT_ACK);
    assign tmr_load  = ((state == ST_SELECT) && (state_nx == ST_EJECT))
                    || ((state == ST_EJECT) && tmr_expire);
    assign tmr_val   = (state == ST_SELECT) ? 8'(PULSE_CYCLES)
                                            : 8'(ACK_TIMEOUT);

    pulse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state decision; ack wins over a timeout on the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:
                if (start)
                    state_nx = ST_SELECT;
            ST_SELECT:
                if (remaining == 8'd0)
                    state_nx = ST_DONE;
                else if (cand != DEN_NONE)
                    state_nx = ST_EJECT;
                else
                    state_nx = ST_FAULT;
            ST_EJECT:
                if (tmr_expire)
                    state_nx = ST_WAIT_ACK;
            ST_WAIT_ACK:
                if (eject_ack)
                    state_nx = ST_SELECT;
                else if (tmr_expire)
                    state_nx = ST_FAULT;
            ST_DONE:
                state_nx = ST_IDLE;
            ST_FAULT:
                state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs can be registered.
    always_comb begin
        busy_nx = (state_nx != ST_IDLE);
        done_nx = (state_nx == ST_DONE);
        e5_nx   = (state_nx == ST_EJECT) && (den_nx == DEN_5);
        e2_nx   = (state_nx == ST_EJECT) && (den_nx == DEN_2);
        e1_nx   = (state_nx == ST_EJECT) && (den_nx == DEN_1);
    end

    // Registered outputs, balance, tube stock and selected coin.
    always_ff @(posedge clk) begin
        if (rst) begin
            eject5    <= 1'b0;
            eject2    <= 1'b0;
            eject1    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            remaining <= 8'd0;
            tube5     <= 4'(TUBE_INIT);
            tube2     <= 4'(TUBE_INIT);
            tube1     <= 4'(TUBE_INIT);
            sel       <= DEN_NONE;
        end else begin
            eject5 <= e5_nx;
            eject2 <= e2_nx;
            eject1 <= e1_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            if (state == ST_IDLE) begin
                if (refill) begin
                    tube5 <= 4'(TUBE_INIT);
                    tube2 <= 4'(TUBE_INIT);
                    tube1 <= 4'(TUBE_INIT);
                end
                if (start) begin
                    remaining <= amount;
                    fault     <= 1'b0;
                end
            end
            if (state == ST_SELECT)
                sel <= cand;
            if (state == ST_WAIT_ACK && eject_ack) begin
                remaining <= remaining - denom_value(sel);
                case (sel)
                    DEN_5:   tube5 <= tube5 - 4'd1;
                    DEN_2:   tube2 <= tube2 - 4'd1;
                    DEN_1:   tube1 <= tube1 - 4'd1;
                    default: ;
                endcase
            end
            if (state_nx == ST_FAULT)
                fault <= 1'b1;
        end
    end

endmodule
